// File: rtl/raabb_hit_collector_if.sv
// Issue/result bundle of raabb_hit_collector: ray issue handshake, pipeline hit bit,
// show-ahead result stream and status outputs.
interface raabb_hit_collector_if #(
  parameter int ID_W    = 8,
  parameter int CNT_W   = 16,
  parameter int LATENCY = 14
);
  localparam int IF_W = $clog2(LATENCY + 1);

  logic             issue_valid;
  logic [ID_W-1:0]  issue_id;
  logic             issue_ready;
  logic             hit_miss;
  logic             res_valid;
  logic             res_ready;
  logic [ID_W-1:0]  res_id;
  logic             res_hit;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [IF_W-1:0]  inflight;
  logic             overrun;

  modport slave (
    input  issue_valid, issue_id, hit_miss, res_ready,
    output issue_ready, res_valid, res_id, res_hit, hit_count, miss_count, inflight, overrun
  );

  modport master (
    output issue_valid, issue_id, hit_miss, res_ready,
    input  issue_ready, res_valid, res_id, res_hit, hit_count, miss_count, inflight, overrun
  );
endinterface

// File: rtl/raabb_hit_collector.sv
// Tags rays into a fixed-latency delay line, pairs them with the free-running
// pipeline's hit bit and buffers {id,hit} in a credit-protected show-ahead FIFO.
module raabb_hit_collector #(
  parameter int LATENCY = 14,
  parameter int ID_W    = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  raabb_hit_collector_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int IF_W = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            hit;
  } res_t;

  logic [LATENCY:1]           vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][ID_W-1:0] id_pipe_q, id_pipe_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              fifo_cnt_q, fifo_cnt_d;
  logic [IF_W-1:0]            inflight_q, inflight_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                       overrun_q, overrun_d;
  logic                       res_valid_q, res_valid_d;
  res_t                       res_q, res_d;
  res_t                       mem_q [DEPTH];

  logic accept, retire, pop, issue_ready;
  res_t wr_data, head;

  // Credit counts both buffered results and tags still in the delay line,
  // so a retiring tag always finds a free FIFO slot.
  assign fifo_cnt_q  = wr_ptr_q - rd_ptr_q;
  assign issue_ready = (32'(fifo_cnt_q) + 32'(inflight_q)) < DEPTH;

  always_comb begin
    accept  = bus.issue_valid & issue_ready;
    retire  = vld_pipe_q[LATENCY];
    pop     = res_valid_q & bus.res_ready;
    wr_data = '{id: id_pipe_q[LATENCY], hit: bus.hit_miss};

    vld_pipe_d    = '0;
    id_pipe_d     = '0;
    vld_pipe_d[1] = accept;
    id_pipe_d[1]  = bus.issue_id;
    for (int k = 2; k <= LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      id_pipe_d[k]  = id_pipe_q[k-1];
    end

    wr_ptr_d   = wr_ptr_q + PW'(retire);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    fifo_cnt_d = wr_ptr_d - rd_ptr_d;
    inflight_d = inflight_q + IF_W'(accept) - IF_W'(retire);

    // Next head may be the entry landing this very edge, before mem_q holds it.
    head        = (rd_ptr_d == wr_ptr_q) ? wr_data : mem_q[rd_ptr_d[AW-1:0]];
    res_valid_d = fifo_cnt_d != '0;
    res_d       = res_valid_d ? head : res_q;

    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (retire && bus.hit_miss && hit_cnt_q != '1)    hit_cnt_d  = hit_cnt_q + 1'b1;
    if (retire && !bus.hit_miss && miss_cnt_q != '1)  miss_cnt_d = miss_cnt_q + 1'b1;

    overrun_d = overrun_q | (bus.issue_valid & ~issue_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      overrun_q   <= overrun_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (retire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign bus.issue_ready = issue_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_q.id;
  assign bus.res_hit     = res_q.hit;
  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;
  assign bus.inflight    = inflight_q;
  assign bus.overrun     = overrun_q;
endmodule
